// File: rtl/e1_crc4_rx_ctrl.sv
// Receive-side CRC-4 sequencer for the E1 framer: per-SMF CRC check against the
// C-bits carried in the following SMF, E-bit feed and saturating error count.

module e1_crc4 #(
   parameter logic [3:0] INIT = 4'h0,
   parameter logic [3:0] POLY = 4'h3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_first,
   input  logic       in_bit,
   output logic [3:0] crc
);

   logic [3:0] base;
   logic       fb;

   always_comb begin
      base = in_first ? INIT : crc;
      fb   = base[3] ^ in_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc <= INIT;
      else if (in_valid)
         crc <= {base[2:0], 1'b0} ^ (fb ? POLY : 4'h0);
   end

endmodule

module e1_crc4_rx_ctrl #(
   parameter int ERR_CNT_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_bit,
   input  logic                 in_valid,
   input  logic [3:0]           in_frame,
   input  logic [4:0]           in_ts,
   input  logic [2:0]           in_bitpos,
   input  logic                 in_mf_lock,
   output logic                 smf_stb,
   output logic                 smf_crc_ok,
   output logic                 smf_crc_err,
   output logic                 e_bit,
   output logic [3:0]           crc_last,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_cnt_clr
);

   typedef enum logic [1:0] {OFF, PRIME, RUN} state_t;

   state_t     state;
   logic       smf_start, smf_end, c_pos;
   logic       eng_valid, eng_bit;
   logic [3:0] eng_crc;
   logic [3:0] rx_c;
   logic       cap_pend, cap_chk;

   always_comb begin
      smf_start = in_valid && (in_frame == 4'd0 || in_frame == 4'd8) &&
                  in_ts == 5'd0 && in_bitpos == 3'd0;
      smf_end   = in_valid && (in_frame == 4'd7 || in_frame == 4'd15) &&
                  in_ts == 5'd31 && in_bitpos == 3'd7;
      c_pos     = in_ts == 5'd0 && in_bitpos == 3'd0 && !in_frame[0];
      eng_valid = in_valid && in_mf_lock && (state != OFF || smf_start);
      eng_bit   = c_pos ? 1'b0 : in_bit;
   end

   e1_crc4 #(.INIT(4'h0), .POLY(4'h3)) u_crc (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (eng_valid),
      .in_first (smf_start),
      .in_bit   (eng_bit),
      .crc      (eng_crc)
   );

   // The SMF-end bit lands in the engine on the edge ending T, so the remainder
   // is captured one cycle later; a start bit in T+1 only affects the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= OFF;
         rx_c        <= '0;
         cap_pend    <= 1'b0;
         cap_chk     <= 1'b0;
         crc_last    <= '0;
         smf_stb     <= 1'b0;
         smf_crc_ok  <= 1'b0;
         smf_crc_err <= 1'b0;
         e_bit       <= 1'b1;
      end else begin
         cap_pend    <= 1'b0;
         smf_stb     <= 1'b0;
         smf_crc_ok  <= 1'b0;
         smf_crc_err <= 1'b0;

         if (!in_mf_lock) begin
            state <= OFF;
         end else begin
            case (state)
               OFF:   if (smf_start) state <= PRIME;
               PRIME: if (smf_end) begin
                         state    <= RUN;
                         cap_pend <= 1'b1;
                         cap_chk  <= 1'b0;
                      end
               RUN:   if (smf_end) begin
                         cap_pend <= 1'b1;
                         cap_chk  <= 1'b1;
                      end
               default: state <= OFF;
            endcase
         end

         if (eng_valid && c_pos)
            rx_c[~in_frame[2:1]] <= in_bit;

         if (cap_pend) begin
            crc_last <= eng_crc;
            if (cap_chk) begin
               smf_stb     <= 1'b1;
               smf_crc_ok  <= (rx_c == crc_last);
               smf_crc_err <= (rx_c != crc_last);
               e_bit       <= (rx_c == crc_last);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (err_cnt_clr)
         err_cnt <= smf_crc_err ? ERR_CNT_W'(1) : '0;
      else if (smf_crc_err && err_cnt != '1)
         err_cnt <= err_cnt + ERR_CNT_W'(1);
   end

endmodule

// File: tb/tb_e1_crc4_rx_ctrl.sv
// Scoreboard bench for e1_crc4_rx_ctrl: random multiframes, expected SMF results
// from a polynomial-division reference model, checked by a decoupled monitor.

module tb_e1_crc4_rx_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_bit = 1'b0, in_valid = 1'b0, in_mf_lock = 1'b0, err_cnt_clr = 1'b0;
   logic [3:0] in_frame = '0;
   logic [4:0] in_ts = '0;
   logic [2:0] in_bitpos = '0;

   logic a_stb, a_ok, a_err, a_e, b_stb, b_ok, b_err, b_e;
   logic [3:0] a_crc, b_crc;
   logic [9:0] a_cnt;
   logic [2:0] b_cnt;

   e1_crc4_rx_ctrl #(.ERR_CNT_W(10)) u_a (
      .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
      .in_frame(in_frame), .in_ts(in_ts), .in_bitpos(in_bitpos),
      .in_mf_lock(in_mf_lock), .smf_stb(a_stb), .smf_crc_ok(a_ok),
      .smf_crc_err(a_err), .e_bit(a_e), .crc_last(a_crc), .err_cnt(a_cnt),
      .err_cnt_clr(err_cnt_clr));

   e1_crc4_rx_ctrl #(.ERR_CNT_W(3)) u_b (
      .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
      .in_frame(in_frame), .in_ts(in_ts), .in_bitpos(in_bitpos),
      .in_mf_lock(in_mf_lock), .smf_stb(b_stb), .smf_crc_ok(b_ok),
      .smf_crc_err(b_err), .e_bit(b_e), .crc_last(b_crc), .err_cnt(b_cnt),
      .err_cnt_clr(err_cnt_clr));

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        ok;
      logic [3:0]  crc;
      int unsigned cyc;
   } exp_t;

   exp_t q[$];
   int   tests = 0, fails = 0;

   // reference model state
   logic          cur_lock = 1'b0;
   logic          m_active = 1'b0, m_prime = 1'b0;
   logic [3:0]    m_rxc = '0, m_prev = '0;
   logic [2047:0] rx_vec, gen_vec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // remainder of M(x)*x^4 divided by x^4+x+1, first bit on line = highest power
   function automatic logic [3:0] rem_of(input logic [2047:0] v);
      logic [2051:0] r;
      r = {v, 4'b0000};
      for (int i = 2051; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   task automatic drive(input logic b, input logic v, input int f, input int ts,
                        input int bp, input logic clr);
      @(posedge clk);
      #1;
      in_bit      = b;
      in_valid    = v;
      in_frame    = 4'(f);
      in_ts       = 5'(ts);
      in_bitpos   = 3'(bp);
      in_mf_lock  = cur_lock;
      err_cnt_clr = clr;
   endtask

   task automatic idle(input logic clr);
      drive(1'b0, 1'b0, 0, 1, 1, clr);
   endtask

   task automatic send(input logic b, input int f, input int ts, input int bp);
      logic start, fin, cpos;
      logic [3:0] r;
      int k;
      drive(b, 1'b1, f, ts, bp, 1'b0);
      start = (f % 8 == 0) && ts == 0 && bp == 0;
      fin   = (f % 8 == 7) && ts == 31 && bp == 7;
      cpos  = ts == 0 && bp == 0 && (f % 2 == 0);
      k     = (f % 8) * 256 + ts * 8 + bp;
      if (!cur_lock) begin
         m_active = 1'b0;
      end else begin
         if (start && !m_active) begin
            m_active = 1'b1;
            m_prime  = 1'b1;
         end
         if (m_active) begin
            if (cpos) m_rxc[3 - (f % 8) / 2] = b;
            rx_vec[2047 - k] = cpos ? 1'b0 : b;
            if (fin) begin
               r = rem_of(rx_vec);
               if (!m_prime) q.push_back('{m_rxc == m_prev, r, cyc});
               m_prime = 1'b0;
               m_prev  = r;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(1'b0);
      idle(1'b0);
      chk("rst_stb", {a_stb, b_stb, a_ok, a_err, b_ok, b_err}, 0);
      chk("rst_e_bit", {a_e, b_e}, 2'b11);
      chk("rst_crc_last", {a_crc, b_crc}, 0);
      chk("rst_err_cnt", {a_cnt, 1'b0, b_cnt}, 0);
      m_active = 1'b0;
      m_prime  = 1'b0;
      m_rxc    = '0;
      m_prev   = '0;
      q.delete();
      rst_n = 1'b1;
      idle(1'b0);
   endtask

   // fault: 0 none, 1 payload flip, 2 one C-bit flip, 3 lock drop, 4 all C-bits bad
   task automatic run(input int n_mf, input bit gaps, input int fault);
      logic [3:0] gold;
      logic b, cpos, last_end;
      int k;
      gold = 4'($urandom);
      last_end = 1'b0;
      for (int mf = 0; mf < n_mf; mf++)
         for (int f = 0; f < 16; f++)
            for (int ts = 0; ts < 32; ts++)
               for (int bp = 0; bp < 8; bp++) begin
                  k    = (f % 8) * 256 + ts * 8 + bp;
                  cpos = ts == 0 && bp == 0 && (f % 2 == 0);
                  b    = cpos ? gold[3 - (f % 8) / 2] : 1'($urandom);
                  gen_vec[2047 - k] = cpos ? 1'b0 : b;
                  if (fault == 1 && mf == 0 && f == 9 && ts == 5 && bp == 3) b = ~b;
                  if (fault == 2 && mf == 1 && f == 0 && cpos) b = ~b;
                  if (fault == 4 && cpos) b = ~b;
                  cur_lock = !(fault == 3 && mf == 1 && f < 11 &&
                               (f > 4 || (f == 4 && ts >= 10)));
                  if (gaps && !last_end)
                     for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) idle(1'b0);
                  send(b, f, ts, bp);
                  last_end = (f % 8 == 7) && ts == 31 && bp == 7;
                  if (last_end) gold = rem_of(gen_vec);
                  if (fault == 4 && last_end && mf == n_mf - 1 && f == 15) begin
                     chk("sat_w3", 32'(b_cnt), 7);
                     chk("cnt_w10_before_clr", 32'(a_cnt), 8);
                     idle(1'b0);
                     idle(1'b1);
                     idle(1'b0);
                     chk("clr_with_err_w3", 32'(b_cnt), 1);
                     chk("clr_with_err_w10", 32'(a_cnt), 1);
                     idle(1'b1);
                     idle(1'b0);
                     chk("clr_alone_w3", 32'(b_cnt), 0);
                     chk("clr_alone_w10", 32'(a_cnt), 0);
                  end
               end
      repeat (4) idle(1'b0);
      chk("queue_drained", q.size(), 0);
   endtask

   // monitor
   int   cnt_a = 0, cnt_b = 0;
   logic ebit = 1'b1, err_now;
   exp_t e;

   always @(negedge clk) begin
      if (!rst_n) begin
         cnt_a = 0;
         cnt_b = 0;
         ebit  = 1'b1;
      end else begin
         chk("err_cnt_w10", 32'(a_cnt), cnt_a);
         chk("err_cnt_w3", 32'(b_cnt), cnt_b);
         err_now = 1'b0;
         if (a_stb || b_stb) begin
            chk("stb_pair", {a_stb, b_stb}, 2'b11);
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               ebit    = e.ok;
               err_now = !e.ok;
               chk("strobe_cycle", cyc, e.cyc + 2);
               chk("ok_err_w10", {a_ok, a_err}, {e.ok, !e.ok});
               chk("ok_err_w3", {b_ok, b_err}, {e.ok, !e.ok});
               chk("crc_last", {a_crc, b_crc}, {e.crc, e.crc});
            end
         end else begin
            chk("idle_flags", {a_ok, a_err, b_ok, b_err}, 0);
         end
         chk("e_bit", {a_e, b_e}, {ebit, ebit});
         if (err_cnt_clr) begin
            cnt_a = err_now ? 1 : 0;
            cnt_b = err_now ? 1 : 0;
         end else if (err_now) begin
            if (cnt_a != 1023) cnt_a++;
            if (cnt_b != 7) cnt_b++;
         end
      end
   end

   initial begin
      cur_lock = 1'b1;
      do_reset();
      run(4, 1'b0, 0);
      chk("clean_err_cnt", 32'(a_cnt), 0);
      do_reset();
      run(2, 1'b0, 1);
      chk("payload_err_cnt", 32'(a_cnt), 1);
      chk("payload_e_bit", 32'(a_e), 1);
      do_reset();
      run(2, 1'b0, 2);
      chk("cbit_err_cnt", 32'(a_cnt), 1);
      do_reset();
      run(4, 1'b0, 3);
      chk("lock_err_cnt", 32'(a_cnt), 0);
      do_reset();
      run(2, 1'b1, 0);
      chk("gap_err_cnt", 32'(a_cnt), 0);
      for (int i = 0; i < 300; i++) send(1'($urandom), i / 256, (i / 8) % 32, i % 8);
      do_reset();
      run(5, 1'b0, 4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
